oram_avalon_bridge: RTL and testbench

- Avalon-MM slave front end that sequences CPU word accesses into the ORAM core's single-outstanding request/response handshake.
- Adds waitrequest/readdatavalid flow control.
- Performs read-modify-write for partial-byteenable writes, since the ORAM core only moves whole words.
- Sits between the system interconnect and the ORAM core, one request in flight at a time.

---
 rtl/oram_avalon_bridge.sv | 145 ++++++++++++++
 tb/tb_oram_avalon_bridge.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oram_avalon_bridge.sv
// rtl/oram_avalon_bridge.sv - Avalon-MM slave to single-outstanding ORAM core bridge; ORAM_BRIDGE_RMW_EN enables read-modify-write of partial writes
module oram_avalon_bridge #(
   parameter int ADDRESS_WIDTH  = 12,
   parameter int BYTE_WIDTH     = 8,
   parameter int BYTES_PER_WORD = 4,
   localparam int W = BYTE_WIDTH * BYTES_PER_WORD
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [ADDRESS_WIDTH-1:0]  avs_a_address,
   input  logic [BYTES_PER_WORD-1:0] avs_a_byteenable,
   input  logic                      avs_a_read,
   input  logic                      avs_a_write,
   input  logic [W-1:0]              avs_a_writedata,
   output logic                      avs_a_waitrequest,
   output logic [W-1:0]              avs_a_readdata,
   output logic                      avs_a_readdatavalid,
   output logic [ADDRESS_WIDTH-1:0]  rw_block_number,
   output logic [W-1:0]              w_value,
   output logic                      rw_indicator,
   output logic                      input_ready,
   input  logic [W-1:0]              r_value,
   input  logic                      output_ready,
   output logic                      spurious_ready
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
`ifdef ORAM_BRIDGE_RMW_EN
   typedef enum logic [1:0] {OP_RD, OP_WR, OP_RMW_RD} op_t;
`else
   typedef enum logic {OP_RD, OP_WR} op_t;
`endif

   state_t state;
   op_t    op;
   logic   be_none;

   assign be_none = ~|avs_a_byteenable;

   // Decoded from state (and reset) only, so no input-to-output combinational path.
   assign avs_a_waitrequest = (state != IDLE) | reset;

`ifdef ORAM_BRIDGE_RMW_EN
   logic                      be_full;
   logic [BYTES_PER_WORD-1:0] be_reg;
   logic [W-1:0]              merged;

   assign be_full = &avs_a_byteenable;

   // w_value still holds the latched writedata, so enabled lanes keep it.
   always_comb begin
      merged = r_value;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         if (be_reg[i]) begin
            merged[i*BYTE_WIDTH +: BYTE_WIDTH] = w_value[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state               <= IDLE;
         op                  <= OP_RD;
         input_ready         <= 1'b0;
         rw_indicator        <= 1'b0;
         avs_a_readdatavalid <= 1'b0;
         spurious_ready      <= 1'b0;
         rw_block_number     <= '0;
         w_value             <= '0;
         avs_a_readdata      <= '0;
`ifdef ORAM_BRIDGE_RMW_EN
         be_reg              <= '0;
`endif
      end else begin
         input_ready         <= 1'b0;
         avs_a_readdatavalid <= 1'b0;
         if (output_ready && state != WAIT) begin
            spurious_ready <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (avs_a_write && !be_none) begin
                  rw_block_number <= avs_a_address;
                  w_value         <= avs_a_writedata;
                  input_ready     <= 1'b1;
                  state           <= ISSUE;
`ifdef ORAM_BRIDGE_RMW_EN
                  if (be_full) begin
                     op           <= OP_WR;
                     rw_indicator <= 1'b1;
                  end else begin
                     op           <= OP_RMW_RD;
                     rw_indicator <= 1'b0;
                     be_reg       <= avs_a_byteenable;
                  end
`else
                  op           <= OP_WR;
                  rw_indicator <= 1'b1;
`endif
               end else if (avs_a_read && !avs_a_write) begin
                  rw_block_number <= avs_a_address;
                  op              <= OP_RD;
                  rw_indicator    <= 1'b0;
                  input_ready     <= 1'b1;
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (output_ready) begin
                  case (op)
                     OP_RD: begin
                        avs_a_readdata      <= r_value;
                        avs_a_readdatavalid <= 1'b1;
                        state               <= RESP;
                     end
`ifdef ORAM_BRIDGE_RMW_EN
                     OP_RMW_RD: begin
                        w_value      <= merged;
                        op           <= OP_WR;
                        rw_indicator <= 1'b1;
                        input_ready  <= 1'b1;
                        state        <= ISSUE;
                     end
`endif
                     default: begin
                        state <= IDLE;
                     end
                  endcase
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oram_avalon_bridge.sv
// tb/tb_oram_avalon_bridge.sv - scoreboard bench for oram_avalon_bridge with a latency-programmable core model
module tb_oram_avalon_bridge;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] avs_a_address = '0;
   logic [3:0]  avs_a_byteenable = '0;
   logic        avs_a_read = 1'b0;
   logic        avs_a_write = 1'b0;
   logic [31:0] avs_a_writedata = '0;
   logic        avs_a_waitrequest;
   logic [31:0] avs_a_readdata;
   logic        avs_a_readdatavalid;
   logic [11:0] rw_block_number;
   logic [31:0] w_value;
   logic        rw_indicator;
   logic        input_ready;
   logic [31:0] r_value = '0;
   logic        output_ready = 1'b0;
   logic        spurious_ready;

   oram_avalon_bridge dut (
      .clock               (clock),
      .reset               (reset),
      .avs_a_address       (avs_a_address),
      .avs_a_byteenable    (avs_a_byteenable),
      .avs_a_read          (avs_a_read),
      .avs_a_write         (avs_a_write),
      .avs_a_writedata     (avs_a_writedata),
      .avs_a_waitrequest   (avs_a_waitrequest),
      .avs_a_readdata      (avs_a_readdata),
      .avs_a_readdatavalid (avs_a_readdatavalid),
      .rw_block_number     (rw_block_number),
      .w_value             (w_value),
      .rw_indicator        (rw_indicator),
      .input_ready         (input_ready),
      .r_value             (r_value),
      .output_ready        (output_ready),
      .spurious_ready      (spurious_ready)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      bit          rw;
      logic [11:0] addr;
      logic [31:0] wv;
      bit          chk_w;
      int          cyc;
   } req_t;
   typedef struct {
      logic [31:0] data;
      int          cyc;
   } rdv_t;
   typedef struct {
      int          lat;
      logic [31:0] val;
   } core_t;

   req_t  req_q[$];
   rdv_t  rdv_q[$];
   core_t core_q[$];

   int checks = 0;
   int failures = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_req(input bit rw, input logic [11:0] a, input logic [31:0] wv,
                          input bit chk_w, input int c);
      req_t r;
      r.rw = rw; r.addr = a; r.wv = wv; r.chk_w = chk_w; r.cyc = c;
      req_q.push_back(r);
   endtask

   task automatic exp_rdv(input logic [31:0] d, input int c);
      rdv_t r;
      r.data = d; r.cyc = c;
      rdv_q.push_back(r);
   endtask

   task automatic core_rsp(input int lat, input logic [31:0] v);
      core_t r;
      r.lat = lat; r.val = v;
      core_q.push_back(r);
   endtask

   // Monitor: every request strobe and read response is popped against the scoreboard.
   req_t mon_req;
   rdv_t mon_rdv;
   always @(negedge clock) begin
      if (input_ready) begin
         if (req_q.size() == 0) begin
            check32("unexpected_input_ready", 32'd1, 32'd0);
         end else begin
            mon_req = req_q.pop_front();
            check32("req_rw", 32'(rw_indicator), 32'(mon_req.rw));
            check32("req_addr", 32'(rw_block_number), 32'(mon_req.addr));
            if (mon_req.chk_w) check32("req_wvalue", w_value, mon_req.wv);
            check32("req_cycle", 32'(cyc), 32'(mon_req.cyc));
         end
      end
      if (avs_a_readdatavalid) begin
         if (rdv_q.size() == 0) begin
            check32("unexpected_readdatavalid", 32'd1, 32'd0);
         end else begin
            mon_rdv = rdv_q.pop_front();
            check32("rdv_data", avs_a_readdata, mon_rdv.data);
            check32("rdv_cycle", 32'(cyc), 32'(mon_rdv.cyc));
         end
      end
   end

   // Core model: answers each request after its programmed latency.
   core_t ce;
   initial begin
      forever begin
         @(negedge clock);
         if (input_ready && core_q.size() > 0) begin
            ce = core_q.pop_front();
            repeat (ce.lat) @(posedge clock);
            #1;
            output_ready = 1'b1;
            r_value      = ce.val;
            @(posedge clock);
            #1;
            output_ready = 1'b0;
         end
      end
   end

   task automatic cmd(input bit rd, input bit wr, input logic [11:0] a, input logic [3:0] be,
                      input logic [31:0] d, output int t);
      int g = 0;
      while (avs_a_waitrequest && g < 200) begin
         @(posedge clock);
         #1;
         g++;
      end
      if (g >= 200) check32("cmd_accept_timeout", 32'd1, 32'd0);
      avs_a_read       = rd;
      avs_a_write      = wr;
      avs_a_address    = a;
      avs_a_byteenable = be;
      avs_a_writedata  = d;
      t = cyc;
      @(posedge clock);
      #1;
      avs_a_read  = 1'b0;
      avs_a_write = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int exp_cyc);
      int g = 0;
      while (avs_a_waitrequest && g < 200) begin
         @(posedge clock);
         #1;
         g++;
      end
      check32(name, 32'(cyc), 32'(exp_cyc));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "bench watchdog expired");
   end

   int t, t2;
   initial begin
      repeat (3) @(posedge clock);
      #1;
      check32("rst_waitrequest", 32'(avs_a_waitrequest), 32'd1);
      check32("rst_input_ready", 32'(input_ready), 32'd0);
      check32("rst_rw_indicator", 32'(rw_indicator), 32'd0);
      check32("rst_readdatavalid", 32'(avs_a_readdatavalid), 32'd0);
      check32("rst_spurious", 32'(spurious_ready), 32'd0);
      check32("rst_block_number", 32'(rw_block_number), 32'd0);
      check32("rst_w_value", w_value, 32'd0);
      check32("rst_readdata", avs_a_readdata, 32'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check32("post_rst_waitrequest", 32'(avs_a_waitrequest), 32'd0);

      // Read, L=3
      core_rsp(3, 32'hDEADBEEF);
      cmd(1'b1, 1'b0, 12'h005, 4'h0, 32'h0, t);
      exp_req(1'b0, 12'h005, 32'h0, 1'b0, t + 1);
      exp_rdv(32'hDEADBEEF, t + 5);
      check32("read_waitrequest_t1", 32'(avs_a_waitrequest), 32'd1);
      wait_idle("read_idle_cycle", t + 6);

      // Full write, L=2
      core_rsp(2, 32'h0);
      cmd(1'b0, 1'b1, 12'hFFF, 4'hF, 32'h12345678, t);
      exp_req(1'b1, 12'hFFF, 32'h12345678, 1'b1, t + 1);
      wait_idle("full_write_idle_cycle", t + 4);
      check32("readdata_hold", avs_a_readdata, 32'hDEADBEEF);

      // Partial writes
`ifdef ORAM_BRIDGE_RMW_EN
      core_rsp(2, 32'h11223344);
      core_rsp(1, 32'h0);
      cmd(1'b0, 1'b1, 12'h3A5, 4'h3, 32'hAAAABBBB, t);
      exp_req(1'b0, 12'h3A5, 32'h0, 1'b0, t + 1);
      exp_req(1'b1, 12'h3A5, 32'h1122BBBB, 1'b1, t + 4);
      wait_idle("rmw_idle_cycle", t + 6);

      core_rsp(1, 32'h01234567);
      core_rsp(2, 32'h0);
      cmd(1'b0, 1'b1, 12'h010, 4'h9, 32'hCAFEF00D, t);
      exp_req(1'b0, 12'h010, 32'h0, 1'b0, t + 1);
      exp_req(1'b1, 12'h010, 32'hCA23450D, 1'b1, t + 3);
      wait_idle("rmw2_idle_cycle", t + 6);
`else
      core_rsp(2, 32'h0);
      cmd(1'b0, 1'b1, 12'h3A5, 4'h3, 32'hAAAABBBB, t);
      exp_req(1'b1, 12'h3A5, 32'hAAAABBBB, 1'b1, t + 1);
      wait_idle("partial_idle_cycle", t + 4);

      core_rsp(2, 32'h0);
      cmd(1'b0, 1'b1, 12'h010, 4'h9, 32'hCAFEF00D, t);
      exp_req(1'b1, 12'h010, 32'hCAFEF00D, 1'b1, t + 1);
      wait_idle("partial2_idle_cycle", t + 4);
`endif

      // No-op write then back-to-back read
      cmd(1'b0, 1'b1, 12'h077, 4'h0, 32'hDEADDEAD, t);
      check32("noop_waitrequest", 32'(avs_a_waitrequest), 32'd0);
      core_rsp(1, 32'h0BADF00D);
      cmd(1'b1, 1'b0, 12'h0AB, 4'h0, 32'h0, t2);
      check32("noop_b2b_accept_cycle", 32'(t2), 32'(t + 1));
      exp_req(1'b0, 12'h0AB, 32'h0, 1'b0, t2 + 1);
      exp_rdv(32'h0BADF00D, t2 + 3);
      wait_idle("b2b_read_idle_cycle", t2 + 4);

      // Reset during WAIT of a read, core answers late
      core_rsp(6, 32'h00000055);
      cmd(1'b1, 1'b0, 12'h123, 4'h0, 32'h0, t);
      exp_req(1'b0, 12'h123, 32'h0, 1'b0, t + 1);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check32("rst_mid_waitrequest", 32'(avs_a_waitrequest), 32'd0);
      check32("rst_mid_spurious_clear", 32'(spurious_ready), 32'd0);
      while (cyc < t + 9) begin
         @(posedge clock);
         #1;
      end
      check32("late_ready_spurious", 32'(spurious_ready), 32'd1);

      // Read and write together -> write
      core_rsp(1, 32'h0);
      cmd(1'b1, 1'b1, 12'h0C3, 4'hF, 32'h87654321, t);
      exp_req(1'b1, 12'h0C3, 32'h87654321, 1'b1, t + 1);
      wait_idle("rw_both_idle_cycle", t + 3);
      check32("readdata_after_reset", avs_a_readdata, 32'd0);
      check32("spurious_sticky", 32'(spurious_ready), 32'd1);

      repeat (5) @(posedge clock);
      #1;
      check32("req_queue_drained", 32'(req_q.size()), 32'd0);
      check32("rdv_queue_drained", 32'(rdv_q.size()), 32'd0);
      check32("core_queue_drained", 32'(core_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
